// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for the decode stage.
// Extracts and extends RV32I/RV64I immediates (I, S, B, U, J, shift amount),
// flags illegal format selects, and decouples producer and consumer with an
// output register plus one skid entry so a stall never drops or repeats work.
module imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          Instr,
  input  logic [2:0]           ImmSrc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      ImmExt,
  output logic                 ImmErr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [2:0] SRC_I     = 3'b000;
  localparam logic [2:0] SRC_S     = 3'b001;
  localparam logic [2:0] SRC_B     = 3'b010;
  localparam logic [2:0] SRC_U     = 3'b011;
  localparam logic [2:0] SRC_J     = 3'b100;
  localparam logic [2:0] SRC_SHAMT = 3'b101;

  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  logic            in_illegal;
  logic            in_fire;
  logic            out_fire;

  logic                 or_valid_q, or_valid_d;
  logic [XLEN-1:0]      or_imm_q,   or_imm_d;
  logic                 or_err_q,   or_err_d;
  logic                 sk_valid_q, sk_valid_d;
  logic [XLEN-1:0]      sk_imm_q,   sk_imm_d;
  logic                 sk_err_q,   sk_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q,  err_cnt_d;

  assign in_illegal = (ImmSrc[2:1] == 2'b11);

  // Build the immediate as a 32-bit value; every format except the shift
  // amount sign-extends from bit 31, and the shift amount (and illegal zero)
  // always has bit 31 clear, so one sign extension covers all cases at XLEN=64.
  always_comb begin
    imm32 = 32'b0;
    unique case (ImmSrc)
      SRC_I:     imm32 = {{20{Instr[31]}}, Instr[31:20]};
      SRC_S:     imm32 = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
      SRC_B:     imm32 = {{20{Instr[31]}}, Instr[7], Instr[30:25], Instr[11:8], 1'b0};
      SRC_U:     imm32 = {Instr[31:12], 12'b0};
      SRC_J:     imm32 = {{12{Instr[31]}}, Instr[19:12], Instr[20], Instr[30:21], 1'b0};
      SRC_SHAMT: imm32 = (XLEN == 64) ? {26'b0, Instr[25:20]} : {27'b0, Instr[24:20]};
      default:   imm32 = 32'b0;
    endcase
  end

  if (XLEN == 64) begin : g_x64
    assign imm_ext = {{32{imm32[31]}}, imm32};
  end else begin : g_x32
    assign imm_ext = imm32;
  end

  // in_ready depends only on the skid register, so it is a registered signal.
  assign in_ready = !sk_valid_q;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = or_valid_q && out_ready;

  // Next-state for output register, skid register and illegal counter.
  always_comb begin
    or_valid_d = or_valid_q;
    or_imm_d   = or_imm_q;
    or_err_d   = or_err_q;
    sk_valid_d = sk_valid_q;
    sk_imm_d   = sk_imm_q;
    sk_err_d   = sk_err_q;
    err_cnt_d  = err_cnt_q;
    if (flush) begin
      or_valid_d = 1'b0;
      sk_valid_d = 1'b0;
    end else begin
      if (in_fire && in_illegal && (err_cnt_q != '1))
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      if (!or_valid_q || out_fire) begin
        if (sk_valid_q) begin
          // Older skid entry advances first to keep FIFO order.
          or_valid_d = 1'b1;
          or_imm_d   = sk_imm_q;
          or_err_d   = sk_err_q;
          sk_valid_d = 1'b0;
          if (in_fire) begin
            sk_valid_d = 1'b1;
            sk_imm_d   = imm_ext;
            sk_err_d   = in_illegal;
          end
        end else if (in_fire) begin
          or_valid_d = 1'b1;
          or_imm_d   = imm_ext;
          or_err_d   = in_illegal;
        end else begin
          or_valid_d = 1'b0;
        end
      end else if (in_fire) begin
        sk_valid_d = 1'b1;
        sk_imm_d   = imm_ext;
        sk_err_d   = in_illegal;
      end
    end
  end

  // State registers; reset wins over flush and clears data as well as valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      or_valid_q <= 1'b0;
      or_imm_q   <= '0;
      or_err_q   <= 1'b0;
      sk_valid_q <= 1'b0;
      sk_imm_q   <= '0;
      sk_err_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      or_valid_q <= or_valid_d;
      or_imm_q   <= or_imm_d;
      or_err_q   <= or_err_d;
      sk_valid_q <= sk_valid_d;
      sk_imm_q   <= sk_imm_d;
      sk_err_q   <= sk_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_valid = or_valid_q;
  assign ImmExt    = or_imm_q;
  assign ImmErr    = or_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit instance with a 2-bit error counter and a
// 64-bit instance with an 8-bit counter share all inputs and are compared each
// cycle against a queue-based model, plus directed literal checks.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] Instr;
  logic [2:0]  ImmSrc;

  logic        in_ready32, out_valid32, err32;
  logic [31:0] imm32;
  logic [1:0]  cnt32;
  logic        in_ready64, out_valid64, err64;
  logic [63:0] imm64;
  logic [7:0]  cnt64;

  imm_gen_pipe #(.XLEN(32), .ERR_CNT_W(2)) u_d32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .Instr(Instr), .ImmSrc(ImmSrc),
    .out_valid(out_valid32), .out_ready(out_ready),
    .ImmExt(imm32), .ImmErr(err32), .err_cnt(cnt32)
  );

  imm_gen_pipe #(.XLEN(64), .ERR_CNT_W(8)) u_d64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .Instr(Instr), .ImmSrc(ImmSrc),
    .out_valid(out_valid64), .out_ready(out_ready),
    .ImmExt(imm64), .ImmErr(err64), .err_cnt(cnt64)
  );

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference immediate from the ISA field layout, computed as 64-bit signed
  // arithmetic on the sign-extended instruction word.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                          input bit x64);
    longint si, t, sgn;
    si  = {{32{ins[31]}}, ins};
    sgn = si >>> 31;
    case (src)
      3'd0: begin t = si >>> 20; return t; end
      3'd1: begin t = si >>> 25; return (t << 5) | 64'(ins[11:7]); end
      3'd2: return (sgn << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5)
                   | (64'(ins[11:8]) << 1);
      3'd3: return si & 64'hFFFF_FFFF_FFFF_F000;
      3'd4: return (sgn << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11)
                   | (64'(ins[30:21]) << 1);
      3'd5: return x64 ? 64'(ins[25:20]) : 64'(ins[24:20]);
      default: return 64'd0;
    endcase
  endfunction

  // Model: the block is a FIFO of at most two entries; head is the output.
  typedef struct {
    logic [31:0] ins;
    logic [2:0]  src;
  } ent_t;
  ent_t q[$];
  int   cnt = 0;
  bit   model_ok = 0;

  always @(posedge clk) begin
    bit fo, fi;
    if (rst) begin
      q.delete();
      cnt = 0;
      model_ok = 1;
    end else if (flush) begin
      q.delete();
    end else begin
      fo = (q.size() > 0) && out_ready;
      fi = in_valid && (q.size() < 2);
      if (fo) void'(q.pop_front());
      if (fi) begin
        q.push_back('{ins: Instr, src: ImmSrc});
        if (ImmSrc >= 3'd6) cnt++;
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    logic [63:0] e;
    if (model_ok) begin
      chk("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
      chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
      chk("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
      chk("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
      chk("err_cnt32", 64'(cnt32), 64'((cnt > 3) ? 3 : cnt));
      chk("err_cnt64", 64'(cnt64), 64'((cnt > 255) ? 255 : cnt));
      if (q.size() > 0) begin
        e = ref_imm(q[0].ins, q[0].src, 1'b0);
        chk("imm32", 64'(imm32), {32'b0, e[31:0]});
        chk("imm64", imm64, ref_imm(q[0].ins, q[0].src, 1'b1));
        chk("err32", 64'(err32), 64'(q[0].src >= 3'd6));
        chk("err64", 64'(err64), 64'(q[0].src >= 3'd6));
      end
    end
  end

  localparam logic [31:0] V_INS [6] = '{32'hFFF00093, 32'hFE000EE3, 32'h123450B7,
                                        32'h0080006F, 32'h01F09093, 32'h800000B7};
  localparam logic [2:0]  V_SRC [6] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd3};
  localparam logic [31:0] V_E32 [6] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000,
                                        32'h00000008, 32'h0000001F, 32'h80000000};
  localparam logic [63:0] V_E64 [6] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
                                        64'h0000000012345000, 64'h0000000000000008,
                                        64'h000000000000001F, 64'hFFFFFFFF80000000};

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    logic rdy_prev;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    Instr = 32'b0; ImmSrc = 3'b0;
    repeat (2) cyc();
    chk("rst_out_valid", 64'(out_valid32), 64'd0);
    chk("rst_imm", imm64, 64'd0);
    chk("rst_cnt", 64'(cnt64), 64'd0);
    chk("rst_in_ready", 64'(in_ready32), 64'd1);
    rst = 1'b0;

    // Extension of every legal format at both widths.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; Instr = V_INS[i]; ImmSrc = V_SRC[i];
      cyc();
      chk("dir_valid", 64'(out_valid32), 64'd1);
      chk("dir_imm32", 64'(imm32), 64'(V_E32[i]));
      chk("dir_imm64", imm64, V_E64[i]);
      chk("dir_err", 64'(err32), 64'd0);
    end
    in_valid = 1'b0;
    cyc();

    // Back-pressure: A, B, C offered while downstream stalls.
    out_ready = 1'b0; in_valid = 1'b1; ImmSrc = 3'd0;
    Instr = 32'h00100013; cyc();
    chk("bp_a_or", 64'(imm32), 64'd1);
    chk("bp_a_rdy", 64'(in_ready32), 64'd1);
    Instr = 32'h00200013; cyc();
    chk("bp_b_sk", 64'(imm32), 64'd1);
    chk("bp_b_rdy", 64'(in_ready32), 64'd0);
    Instr = 32'h00300013; cyc();
    chk("bp_c_held", 64'(imm32), 64'd1);
    chk("bp_c_rdy", 64'(in_ready32), 64'd0);
    out_ready = 1'b1; cyc();
    chk("bp_out_b", 64'(imm32), 64'd2);
    chk("bp_rdy_back", 64'(in_ready32), 64'd1);
    cyc();
    chk("bp_out_c", 64'(imm32), 64'd3);
    in_valid = 1'b0; cyc();
    chk("bp_drained", 64'(out_valid32), 64'd0);

    // Illegal formats and counter saturation (2-bit counter on u_d32).
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; Instr = $urandom; ImmSrc = (i % 2 == 0) ? 3'd7 : 3'd6;
      cyc();
      chk("ill_imm", 64'(imm32), 64'd0);
      chk("ill_err", 64'(err32), 64'd1);
      chk("ill_cnt32", 64'(cnt32), 64'((i < 3) ? i + 1 : 3));
      chk("ill_cnt64", 64'(cnt64), 64'(i + 1));
    end
    in_valid = 1'b0; cyc();

    // Flush with both entries held, then flush while an input is offered.
    out_ready = 1'b0; in_valid = 1'b1;
    Instr = 32'h00500013; ImmSrc = 3'd0; cyc();
    Instr = 32'h00600013; ImmSrc = 3'd6; cyc();
    chk("fl_full", 64'(in_ready32), 64'd0);
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("fl_valid", 64'(out_valid32), 64'd0);
    chk("fl_rdy", 64'(in_ready32), 64'd1);
    chk("fl_cnt", 64'(cnt64), 64'd7);
    ImmSrc = 3'd7; flush = 1'b1; cyc(); flush = 1'b0;
    chk("fl_drop_valid", 64'(out_valid64), 64'd0);
    chk("fl_drop_cnt", 64'(cnt64), 64'd7);

    // Reset mid-stream.
    Instr = 32'hFFF00093; ImmSrc = 3'd0; cyc();
    chk("mr_loaded", 64'(out_valid32), 64'd1);
    rst = 1'b1; ImmSrc = 3'd7; cyc(); rst = 1'b0; in_valid = 1'b0;
    chk("mr_valid", 64'(out_valid32), 64'd0);
    chk("mr_imm", imm64, 64'd0);
    chk("mr_err", 64'(err64), 64'd0);
    chk("mr_cnt", 64'(cnt64), 64'd0);
    chk("mr_rdy", 64'(in_ready64), 64'd1);

    // Random traffic; producer holds an offer until it is accepted.
    rdy_prev = in_ready32;
    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 49) == 0);
      out_ready = ($urandom_range(0, 3) != 0) || (c % 200 < 20 ? 1'b0 : 1'b0);
      if (c % 200 >= 180) out_ready = 1'b0;
      if (!(in_valid && !rdy_prev)) begin
        in_valid = ($urandom_range(0, 2) != 0);
        Instr    = $urandom;
        ImmSrc   = 3'($urandom_range(0, 7));
      end
      rdy_prev = in_ready32;
      cyc();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
